// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ERROR = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one E-stage ALU operand; the newer M result beats W.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic [REG_AW-1:0] rs_e,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, branch flush, memory-wait FSM.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        ResultSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemAccessM,
  input  logic              mem_ready,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              err_q, err_nxt;
  logic              mem_stall, lw_stall;
  logic [1:0]        fwd_a, fwd_b;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .reg_write_m (RegWriteM),
    .rd_m        (RdM),
    .reg_write_w (RegWriteW),
    .rd_w        (RdW),
    .rs_e        (Rs1E),
    .fwd         (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .reg_write_m (RegWriteM),
    .rd_m        (RdM),
    .reg_write_w (RegWriteW),
    .rd_w        (RdW),
    .rs_e        (Rs2E),
    .fwd         (fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      err_q <= err_nxt;
    end
  end

  // wcnt holds the number of mem_ready-low cycles seen so far for the stalled access
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (MemAccessM && !mem_ready) begin
          state_nxt = WAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (wcnt == WAIT_LIM) begin
          state_nxt = ERROR;
          err_nxt   = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      ERROR: err_nxt = 1'b1;
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // A frozen pipeline holds E, so load-use and branch flushes are retried once it thaws
  always_comb begin
    mem_stall = ((state == IDLE) && MemAccessM && !mem_ready) ||
                (state == WAIT) || (state == ERROR);
    lw_stall  = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst_n) begin
      StallF    = mem_stall | lw_stall;
      StallD    = mem_stall | lw_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushW    = mem_stall;
      FlushD    = !mem_stall & PCSrcE;
      FlushE    = !mem_stall & (PCSrcE | lw_stall);
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
    end
  end

  assign mem_err = err_q;

`ifdef HAZARD_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] stall_q, flush_q;
  logic             any_stall, any_flush;

  assign any_stall = mem_stall | lw_stall;
  assign any_flush = !mem_stall & (PCSrcE | lw_stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (any_stall) stall_q <= sat_inc(stall_q);
      if (any_flush) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int REG_AW   = 5;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 32;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]        ResultSrcE;
  logic              RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready;
  logic              StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [CNT_W-1:0]  stall_cycles, flush_count;
  logic [11:0]       obs, exp_v;

  int checks   = 0;
  int failures = 0;

  // Model: an outstanding access, how many cycles it has waited, sticky error, counters.
  bit     m_busy, m_err;
  int     m_waited;
  longint m_stalls, m_flushes;

  hazard_ctrl #(.REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, mem_err};

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] ref_out();
    logic frozen, lw, br;
    if (!rst_n) return '0;
    frozen = m_err || m_busy || (MemAccessM && !mem_ready);
    lw     = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    br     = PCSrcE;
    return {frozen | lw, frozen | lw, frozen, frozen,
            !frozen & br, !frozen & (br | lw), frozen,
            ref_fwd(Rs1E), ref_fwd(Rs2E), m_err};
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_err = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
  endfunction

  function automatic void model_step(input logic [11:0] e);
`ifdef HAZARD_PERF_EN
    if ((|e[11:8]) && m_stalls < CNT_MAX) m_stalls++;
    if ((e[7] | e[6]) && m_flushes < CNT_MAX) m_flushes++;
`endif
    if (m_err) return;
    if (m_busy) begin
      if (mem_ready) m_busy = 0;
      else if (m_waited == WAIT_MAX) begin m_err = 1; m_busy = 0; end
      else m_waited++;
    end else if (MemAccessM && !mem_ready) begin
      m_busy = 1; m_waited = 1;
    end
  endfunction

  task automatic cycle();
    logic [11:0] e;
    e = ref_out();
    @(posedge clk);
    if (rst_n) model_step(e);
    #1;
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemAccessM = 0; mem_ready = 1;
  endtask

  task automatic rand_inputs(input bit allow_mem);
    Rs1D = REG_AW'($urandom_range(0, 3)); Rs2D = REG_AW'($urandom_range(0, 3));
    Rs1E = REG_AW'($urandom_range(0, 3)); Rs2E = REG_AW'($urandom_range(0, 3));
    RdE  = REG_AW'($urandom_range(0, 3)); RdM  = REG_AW'($urandom_range(0, 3));
    RdW  = REG_AW'($urandom_range(0, 3));
    ResultSrcE = 2'($urandom_range(0, 3));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom); PCSrcE = 1'($urandom);
    MemAccessM = allow_mem ? 1'($urandom) : 1'b0;
    mem_ready  = ($urandom_range(0, 3) != 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    Rs1E = 5; RdM = 5; RegWriteM = 1; Rs1D = 3; RdE = 3; ResultSrcE = 2'b01;
    PCSrcE = 1; MemAccessM = 1; mem_ready = 0; RdW = 0; Rs2D = 0; Rs2E = 0; RegWriteW = 0;
    #12;
    checks++;
    if (obs !== 12'b0) begin failures++; $display("FAIL reset_outputs: got %b want 0", obs); end
    checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      failures++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 12'b0) begin failures++; $display("FAIL reset_idle: got %b want 0", obs); end
    cycle();
  endtask

  task automatic test_forward();
    apply_reset();
    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 6; Rs2E = 6;
    @(negedge clk);
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1001) begin
      failures++; $display("FAIL fwd_m_w: got %b%b want 1001", ForwardAE, ForwardBE);
    end
    cycle();
    RdM = 5; RdW = 5; Rs2E = 5;
    @(negedge clk);
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) begin
      failures++; $display("FAIL fwd_m_priority: got %b%b want 1010", ForwardAE, ForwardBE);
    end
    cycle();
    RdM = 0;
    @(negedge clk);
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0101) begin
      failures++; $display("FAIL fwd_rdm_zero: got %b%b want 0101", ForwardAE, ForwardBE);
    end
    cycle();
    for (int i = 0; i < 40; i++) begin
      rand_inputs(1'b0);
      @(negedge clk);
      exp_v = ref_out();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL fwd_rand[%0d]: got %b want %b", i, obs, exp_v); end
      cycle();
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 7; Rs2D = 3;
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
      failures++; $display("FAIL lw_stall: got %b want 1110", {StallF, StallD, FlushE, StallE});
    end
    cycle();
    ResultSrcE = 2'b00;
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      failures++; $display("FAIL lw_one_cycle: got %b want 000", {StallF, StallD, FlushE});
    end
    cycle();
    ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      failures++; $display("FAIL lw_rd_zero: got %b want 000", {StallF, StallD, FlushE});
    end
    cycle();
  endtask

  task automatic test_branch_lw();
    apply_reset();
    ResultSrcE = 2'b01; RdE = 4; Rs1D = 4; PCSrcE = 1;
    @(negedge clk);
    checks++;
    if ({FlushD, FlushE, StallF, StallD, StallE} !== 5'b11110) begin
      failures++; $display("FAIL branch_lw: got %b want 11110", {FlushD, FlushE, StallF, StallD, StallE});
    end
    cycle();
  endtask

  task automatic test_mem_wait();
    logic [4:0] want;
    apply_reset();
    MemAccessM = 1; PCSrcE = 1;
    for (int i = 0; i < 5; i++) begin
      mem_ready  = (i >= 3);
      MemAccessM = (i <= 3);
      // the ready cycle still sits in WAIT, so the freeze lifts one cycle later
      want = (i <= 3) ? 5'b11111 : 5'b00000;
      @(negedge clk);
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushW} !== want || FlushE !== (i > 3)) begin
        failures++;
        $display("FAIL mem_wait[%0d]: got stalls %b flushE %b want %b %b",
                 i, {StallF, StallD, StallE, StallM, FlushW}, FlushE, want, (i > 3));
      end
      exp_v = ref_out();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL mem_wait_model[%0d]: got %b want %b", i, obs, exp_v); end
      cycle();
    end
  endtask

  task automatic test_watchdog();
    int first;
    apply_reset();
    MemAccessM = 1; mem_ready = 0;
    first = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      @(negedge clk);
      exp_v = ref_out();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL wdog_model[%0d]: got %b want %b", i, obs, exp_v); end
      if (mem_err) first = i;
      cycle();
    end
    checks++;
    if (first != WAIT_MAX + 1) begin failures++; $display("FAIL wdog_latency: got %0d want %0d", first, WAIT_MAX + 1); end
    mem_ready = 1; MemAccessM = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_err !== 1'b1 || StallM !== 1'b1) begin
        failures++; $display("FAIL wdog_sticky[%0d]: got err %b stallM %b want 1 1", i, mem_err, StallM);
      end
      cycle();
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 12'b0) begin failures++; $display("FAIL wdog_reset: got %b want 0", obs); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 12'b0) begin failures++; $display("FAIL wdog_after_reset: got %b want 0", obs); end
    cycle();
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    MemAccessM = 1; mem_ready = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 12'b0 || stall_cycles !== '0 || flush_count !== '0) begin
      failures++; $display("FAIL mid_wait_reset: got %b %0d %0d want 0 0 0", obs, stall_cycles, flush_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    MemAccessM = 0;
    @(negedge clk);
    checks++;
    if ({StallF, StallM, FlushW, FlushD} !== 4'b0001) begin
      failures++; $display("FAIL mid_wait_idle: got %b want 0001", {StallF, StallM, FlushW, FlushD});
    end
    cycle();
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_EN
    localparam int WANT_S = 3, WANT_F = 1;
`else
    localparam int WANT_S = 0, WANT_F = 0;
`endif
    apply_reset();
    MemAccessM = 1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      cycle();
    end
    MemAccessM = 0; mem_ready = 1; PCSrcE = 1;
    cycle();
    PCSrcE = 0;
    @(negedge clk);
    checks++;
    if (stall_cycles !== CNT_W'(WANT_S) || flush_count !== CNT_W'(WANT_F)) begin
      failures++; $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", stall_cycles, flush_count, WANT_S, WANT_F);
    end
    cycle();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      rand_inputs(1'b1);
      @(negedge clk);
      exp_v = ref_out();
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL rand[%0d]: got %b want %b", i, obs, exp_v); end
      checks++;
      if (stall_cycles !== m_stalls[CNT_W-1:0] || flush_count !== m_flushes[CNT_W-1:0]) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cycles, flush_count, m_stalls, m_flushes);
      end
      cycle();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_branch_lw();
    test_mem_wait();
    test_watchdog();
    test_reset_mid_wait();
    test_perf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
